// File: rtl/palette_lut.sv
`default_nettype none
// ============================================================================
// palette_lut : flop-based colour palette with 2-stage lookup and brightness fade
// Optional fade logic enabled by defining PALETTE_FADE_EN.  Revision: 1.0
// ============================================================================
module palette_lut #(
  parameter int INDEX_W  = 5,
  parameter int COLOR_W  = 4,
  parameter int FADE_DIV = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [INDEX_W-1:0]   pix_index,
  input  logic                 pix_valid,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 fade_start,
  input  logic                 fade_dir,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 rgb_valid,
  output logic                 fade_busy,
  output logic                 fade_done
);

  localparam int c_DEPTH = 1 << INDEX_W;
  localparam int c_DATA_W = 3 * COLOR_W;
  localparam int c_LVL_W = COLOR_W + 1;
  localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(1 << COLOR_W);

  logic [c_DATA_W-1:0] r_mem [c_DEPTH];
  logic                r_s1_valid;
  logic [c_DATA_W-1:0] r_s1_data;
  logic [c_LVL_W-1:0]  w_level;

  function automatic logic [COLOR_W-1:0] f_scale(input logic [COLOR_W-1:0] c,
                                                  input logic [c_LVL_W-1:0] lvl);
    return COLOR_W'(({{c_LVL_W{1'b0}}, c} * {{COLOR_W{1'b0}}, lvl}) >> COLOR_W);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Stage 1 samples the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= pix_valid;
      r_s1_data  <= r_mem[pix_index];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      rgb_valid <= r_s1_valid;
      red       <= r_s1_valid ? f_scale(r_s1_data[c_DATA_W-1 -: COLOR_W], w_level) : '0;
      green     <= r_s1_valid ? f_scale(r_s1_data[2*COLOR_W-1 -: COLOR_W], w_level) : '0;
      blue      <= r_s1_valid ? f_scale(r_s1_data[COLOR_W-1:0], w_level) : '0;
    end
  end

`ifdef PALETTE_FADE_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FADING = 2'd1,
    S_DONE   = 2'd2
  } fade_state_t;

  localparam int c_STEP_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(FADE_DIV - 1);

  fade_state_t          r_state, w_state_nxt;
  logic [c_STEP_W-1:0]  r_step, w_step_nxt;
  logic [c_LVL_W-1:0]   r_level, w_level_nxt;
  logic [c_LVL_W-1:0]   r_target, w_target_nxt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_level  <= c_LVL_FULL;
      r_target <= c_LVL_FULL;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    fade_busy    = 1'b0;
    fade_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fade_start) begin
          w_state_nxt  = S_FADING;
          w_target_nxt = fade_dir ? c_LVL_FULL : '0;
          w_step_nxt   = '0;
        end
      end
      S_FADING: begin
        fade_busy = 1'b1;
        if (r_step == c_STEP_LAST) begin
          w_step_nxt = '0;
          // Completion is judged before moving, so an already-at-target fade still waits one step.
          if (r_level == r_target) begin
            w_state_nxt = S_DONE;
          end else if (r_level < r_target) begin
            w_level_nxt = r_level + 1'b1;
          end else begin
            w_level_nxt = r_level - 1'b1;
          end
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      S_DONE: begin
        fade_busy   = 1'b1;
        fade_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_level = r_level;
`else
  logic w_unused;

  assign w_level   = c_LVL_FULL;
  assign fade_busy = 1'b0;
  assign fade_done = 1'b0;
  assign w_unused  = &{1'b0, fade_start, fade_dir, FADE_DIV[0]};
`endif

endmodule
`default_nettype wire

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL have parameter INDEX_W, default 5, palette index width; depth = 2^INDEX_W entries.
REQ-002 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-003 SHALL have parameter FADE_DIV, default 4, clocks per fade level step (>=1).
REQ-004 SHALL have Clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have pix_index  input  INDEX_W  palette index to look up.
REQ-007 SHALL have pix_valid  input  1  pix_index is valid this cycle.
REQ-008 SHALL have wr_en  input  1  write palette entry this cycle.
REQ-009 SHALL have wr_addr  input  INDEX_W  entry to write.
REQ-010 SHALL have wr_data  input  3*COLOR_W  {red,green,blue} to store.
REQ-011 SHALL have fade_start  input  1  single-cycle fade request.
REQ-012 SHALL have fade_dir  input  1  0 = fade to black, 1 = fade to full; sampled with fade_start.
REQ-013 SHALL have red, green, blue  output  COLOR_W each  scaled colour.
REQ-014 SHALL have rgb_valid  output  1  red/green/blue valid this cycle.
REQ-015 SHALL have fade_busy  output  1  fade in progress.
REQ-016 SHALL have fade_done  output  1  one-cycle pulse at fade completion.

Function
REQ-017 Storage SHALL be 2^INDEX_W flop entries of 3*COLOR_W bits; one write port, one read port.
REQ-018 Write: wr_en high -> entry wr_addr takes wr_data at that edge; no handshake, always accepted.
REQ-019 Lookup SHALL be 2-stage pipeline: stage 1 reads entry, stage 2 scales; rgb_valid/colour appear exactly 2 cycles after pix_valid, one result per cycle, no stalls.
REQ-020 Same-cycle write and stage-1 read of the same address SHALL return old (pre-write) data.
REQ-021 Brightness register level, width COLOR_W+1, range 0..2^COLOR_W; each channel out = (c * level) >> COLOR_W, truncated; level = 2^COLOR_W gives c unchanged.
REQ-022 Stage 2 SHALL use the level value present in the cycle the pixel occupies stage 2.
REQ-023 When rgb_valid is 0, red/green/blue SHALL be 0.
REQ-024 Fade FSM states IDLE, FADING, DONE.
REQ-025 IDLE + fade_start -> FADING; target = 0 if fade_dir=0 else 2^COLOR_W; step counter cleared.
REQ-026 FADING: every FADE_DIV clocks, level moves one toward target; when level equals target at a step point -> DONE without further change.
REQ-027 DONE lasts one cycle with fade_done=1, then IDLE.
REQ-028 fade_busy = 1 in FADING and DONE, else 0.
REQ-029 fade_start in FADING or DONE SHALL be ignored.
REQ-030 Fade already at target: FADING reaches DONE after the first FADE_DIV-clock step point; level unchanged.
REQ-031 Writes and lookups SHALL proceed unaffected during a fade.

Reset
REQ-032 Reset SHALL asynchronously clear all palette entries to 0, pipeline valids to 0, outputs red/green/blue/rgb_valid/fade_busy/fade_done to 0.
REQ-033 Reset SHALL set level to 2^COLOR_W, FSM to IDLE, step counter to 0; reset mid-fade aborts the fade with no fade_done pulse.

Configuration
REQ-034 Macro PALETTE_FADE_EN defined: fade FSM, level register and scaling per REQ-021..REQ-030.
REQ-035 PALETTE_FADE_EN undefined: no fade logic; level constant 2^COLOR_W, fade_start/fade_dir ignored, fade_busy and fade_done tied 0, lookup latency still 2 cycles.

Verification
REQ-036 Write entry 3 = 0x473, then pix_index=3 pix_valid=1 -> 2 cycles later rgb_valid=1, RGB = 4,7,3.
REQ-037 Back-to-back pix_valid on indices 0..31 after loading entry i = i*0x081 (mod 0x1000) -> 32 consecutive valid outputs matching entries, in order.
REQ-038 Same cycle wr_en addr 5 data 0xFFF and pix_index 5 (old 0x123) -> output 0x123; next lookup -> 0xFFF.
REQ-039 FADE_DIV=4, fade_dir=0 from level 16 -> level 0 after 64 clocks, fade_done pulse once, entry 0xA84 shown as 5,4,2 when level = 8.
REQ-040 Reset asserted mid-fade at level 9 -> level 16, fade_busy 0, no fade_done, outputs 0, entries 0.
REQ-041 Build without PALETTE_FADE_EN, pulse fade_start -> fade_busy stays 0, colours unscaled.
